i2c_target_regif: RTL

// - I2C target (slave) front end: turns the raw SCL/SDA pins into a byte-wide register-access interface.
// - Feeds the peripheral register/memory decode stage in the top level with rw, addr, wen and wdata.
// - Returns read data to the bus using a rdata / rdata_used handshake.
// - Runs entirely on the system clock; SCL is an oversampled input, not a clock.

---
 rtl/i2c_target_regif_pkg.sv | 21 ++
 rtl/i2c_target_regif_if.sv | 12 +
 rtl/i2c_line_sync.sv | 40 ++++
 rtl/i2c_target_regif.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/i2c_target_regif_pkg.sv
// Shared types and constants for the I2C target register front end.
package i2c_pkg;

    localparam logic [6:0] I2C_ADDR_DEF = 7'h70;
    localparam int         CNT_W        = 4;
    localparam int         BYTE_LEN     = 8;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        REG_ADDR,
        REG_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_target_regif_if.sv
// Byte-wide register access bus between the I2C target and the register decode stage.
interface i2c_target_regif_if;
    logic       rw;
    logic [7:0] addr;
    logic       wen;
    logic [7:0] wdata;
    logic       rdata_used;
    logic [7:0] rdata;

    modport master (output rw, addr, wen, wdata, rdata_used, input rdata);
    modport slave  (input rw, addr, wen, wdata, rdata_used, output rdata);
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers with edge, START and STOP strobes on the system clock.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
    logic                   scl_d, sda_d;
    logic                   scl_s;

    // Idle bus is high, so synchronisers reset to 1 to avoid a false START after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
            scl_d  <= scl_ff[SYNC_STAGES-1];
            sda_d  <= sda_ff[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda_s     = sda_ff[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_target_regif.sv
// I2C target: decodes the bus into register writes and serves reads through rdata/rdata_used.
module i2c_target_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = I2C_ADDR_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sda_i,
    input  logic                      scl,
    output logic                      sda_o,
    output logic                      sda_oe,
    i2c_target_regif_if.master        bus
);
    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda_i     (sda_i),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t       state, state_n;
    logic [CNT_W-1:0] bit_cnt, cnt_n;
    logic [7:0]       shifter, shift_n, addr_q, addr_n, wdata_q, wdata_n, byte_in;
    logic             rw_q, rw_n, oe_q, oe_n, wen_q, wen_n, used_q, used_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shifter <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            wen_q   <= 1'b0;
            used_q  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shifter <= shift_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rw_q    <= rw_n;
            oe_q    <= oe_n;
            wen_q   <= wen_n;
            used_q  <= used_n;
        end
    end

    assign byte_in = {shifter[6:0], sda_s};

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shift_n = shifter;
        addr_n  = wen_q ? addr_q + 8'd1 : addr_q;
        wdata_n = wdata_q;
        rw_n    = rw_q;
        oe_n    = oe_q;
        wen_n   = 1'b0;
        used_n  = 1'b0;
        if (start_det) begin
            state_n = DEV_ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else if (stop_det) begin
            state_n = IDLE;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            unique case (state)
                DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_n = byte_in;
                        cnt_n   = bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(BYTE_LEN - 1)) begin
                            cnt_n = '0;
                            if (state == DEV_ADDR) begin
                                if (byte_in[7:1] == I2C_ADDR) begin
                                    rw_n    = byte_in[0];
                                    state_n = DEV_ACK;
                                end else begin
                                    state_n = WAIT_STOP;
                                end
                            end else if (state == REG_ADDR) begin
                                addr_n  = byte_in;
                                state_n = REG_ACK;
                            end else begin
                                wdata_n = byte_in;
                                wen_n   = 1'b1;
                                state_n = WR_ACK;
                            end
                        end
                    end
                end
                // bit_cnt doubles as the ACK phase: 0 before the 9th rise, 1 after it.
                DEV_ACK, REG_ACK, WR_ACK: begin
                    if (scl_rise) begin
                        cnt_n = CNT_W'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt == '0) begin
                            oe_n = 1'b1;
                        end else begin
                            oe_n  = 1'b0;
                            cnt_n = '0;
                            if (state == DEV_ACK && rw_q) begin
                                shift_n = bus.rdata;
                                used_n  = 1'b1;
                                oe_n    = ~bus.rdata[7];
                                state_n = RD_DATA;
                            end else if (state == DEV_ACK) begin
                                state_n = REG_ADDR;
                            end else begin
                                state_n = WR_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        shift_n = byte_in;
                        cnt_n   = bit_cnt + 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == CNT_W'(BYTE_LEN)) begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = RD_ACK;
                        end else begin
                            oe_n = ~shifter[7];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        addr_n = addr_q + 8'd1;
                        if (!sda_s) cnt_n = CNT_W'(1);
                        else        state_n = WAIT_STOP;
                    end else if (scl_fall && bit_cnt == CNT_W'(1)) begin
                        cnt_n   = '0;
                        shift_n = bus.rdata;
                        used_n  = 1'b1;
                        oe_n    = ~bus.rdata[7];
                        state_n = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_o          = 1'b0;
    assign sda_oe         = oe_q;
    assign bus.rw         = rw_q;
    assign bus.addr       = addr_q;
    assign bus.wen        = wen_q;
    assign bus.wdata      = wdata_q;
    assign bus.rdata_used = used_q;
endmodule
